// File: rtl/life_pkg.sv
// Shared sizing defaults and FSM encodings for the Game-of-Life sequencer.
// Latency and backpressure behaviour live with the modules that import this package.
package life_pkg;

    localparam int LIFE_WIDTH    = 17;
    localparam int LIFE_HEIGHT   = 17;
    localparam int LIFE_GEN_W    = 16;
    localparam int LIFE_CELL_NUM = LIFE_WIDTH * LIFE_HEIGHT;
    localparam int LIFE_ROW_W    = $clog2(LIFE_HEIGHT);
    localparam int LIFE_PTR_W    = $clog2(LIFE_CELL_NUM);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_COMMIT = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_SCAN   = 3'd4;
    localparam logic [2:0] ST_PAUSE  = 3'd5;
    localparam logic [2:0] ST_STEP   = 3'd6;

endpackage

// File: rtl/life_scan_out.sv
// Snapshot register and row-serial scan-out; first row valid the cycle after capture.
// Backpressure: row_data/row_idx hold while row_valid && !row_ready.
module life_scan_out
    import life_pkg::*;
#(
    parameter int WIDTH  = LIFE_WIDTH,
    parameter int HEIGHT = LIFE_HEIGHT,
    localparam int CELL_NUM = WIDTH * HEIGHT,
    localparam int ROW_W    = $clog2(HEIGHT)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                capture,
    input  logic [CELL_NUM-1:0] states,
    input  logic                row_ready,
    output logic [CELL_NUM-1:0] snapshot,
    output logic                row_valid,
    output logic [WIDTH-1:0]    row_data,
    output logic [ROW_W-1:0]    row_idx,
    output logic                row_last,
    output logic                last_accepted
);

    assign row_last      = (row_idx == ROW_W'(HEIGHT - 1));
    assign row_data      = snapshot[int'(row_idx) * WIDTH +: WIDTH];
    assign last_accepted = row_valid & row_ready & row_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snapshot  <= '0;
            row_valid <= 1'b0;
            row_idx   <= '0;
        end else if (capture) begin
            snapshot  <= states;
            row_valid <= 1'b1;
            row_idx   <= '0;
        end else if (row_valid && row_ready) begin
            // Park on row 0 once the scan completes so row_last drops with row_valid.
            if (row_last) begin
                row_valid <= 1'b0;
                row_idx   <= '0;
            end else begin
                row_idx <= row_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/life_seq_ctrl.sv
// Game-of-Life sequencer: serial pattern load, commit, then step / settle / scan until limit or still life.
// A step costs 3 cycles before its scan starts; a stalled scan (row_ready low) holds off all stepping.
module life_seq_ctrl
    import life_pkg::*;
#(
    parameter int WIDTH  = LIFE_WIDTH,
    parameter int HEIGHT = LIFE_HEIGHT,
    parameter int GEN_W  = LIFE_GEN_W,
    localparam int CELL_NUM = WIDTH * HEIGHT,
    localparam int ROW_W    = $clog2(HEIGHT),
    localparam int PTR_W    = $clog2(CELL_NUM)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ld_valid,
    input  logic                ld_data,
    output logic                ld_ready,
    input  logic                run,
    input  logic [GEN_W-1:0]    gens,
    input  logic [CELL_NUM-1:0] states,
    output logic                arr_load,
    output logic [CELL_NUM-1:0] arr_init,
    output logic                arr_step,
    output logic                row_valid,
    input  logic                row_ready,
    output logic [WIDTH-1:0]    row_data,
    output logic [ROW_W-1:0]    row_idx,
    output logic                row_last,
    output logic [GEN_W-1:0]    gen_count,
    output logic                done,
    output logic                stable
);

    logic [2:0]          state, state_nxt;
    logic [PTR_W-1:0]    ptr;
    logic                stepped;
    logic                capture;
    logic                accept;
    logic                last_bit;
    logic                last_accepted;
    logic [CELL_NUM-1:0] snapshot;

    assign accept   = ld_valid & ld_ready;
    assign last_bit = (ptr == PTR_W'(CELL_NUM - 1));
    assign arr_load = (state == ST_COMMIT);
    assign arr_step = (state == ST_STEP);
    // Follows live gens so a limit change takes effect at the next pause decision.
    assign done     = stable | ((gens != '0) && (gen_count >= gens));

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            ST_IDLE, ST_PAUSE: begin
                if (accept)
                    state_nxt = ST_LOAD;
                else if (state == ST_PAUSE && run && !done && !ld_valid)
                    state_nxt = ST_STEP;
            end
            ST_LOAD:   if (accept && last_bit) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_SETTLE;
            ST_STEP:   state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                capture   = 1'b1;
                state_nxt = ST_SCAN;
            end
            ST_SCAN:   if (last_accepted) state_nxt = ST_PAUSE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ld_ready  <= 1'b0;
            ptr       <= '0;
            arr_init  <= '0;
            gen_count <= '0;
            stable    <= 1'b0;
            stepped   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ld_ready <= (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD) || (state_nxt == ST_PAUSE);
            if (accept) begin
                arr_init[ptr] <= ld_data;
                ptr           <= last_bit ? '0 : ptr + 1'b1;
            end
            // Clear status on entry to COMMIT so done is already low while arr_load is high.
            if (state == ST_LOAD && accept && last_bit) begin
                gen_count <= '0;
                stable    <= 1'b0;
            end
            if (state == ST_COMMIT)
                stepped <= 1'b0;
            if (state == ST_STEP) begin
                stepped <= 1'b1;
                if (gen_count != '1)
                    gen_count <= gen_count + 1'b1;
            end
            if (state == ST_SETTLE && stepped)
                stable <= (states == snapshot);
        end
    end

    life_scan_out #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_scan (
        .clock         (clock),
        .reset         (reset),
        .capture       (capture),
        .states        (states),
        .row_ready     (row_ready),
        .snapshot      (snapshot),
        .row_valid     (row_valid),
        .row_data      (row_data),
        .row_idx       (row_idx),
        .row_last      (row_last),
        .last_accepted (last_accepted)
    );

endmodule

// File: tb/tb_life_seq_ctrl.sv
// Bench for life_seq_ctrl: a torus cell-array model on the array ports, scenario table plus hand sequences.
module tb_life_seq_ctrl;

    localparam int W = 17;
    localparam int H = 17;
    localparam int N = W * H;

    logic          clock = 1'b0;
    logic          reset;
    logic          ld_valid, ld_data, ld_ready, run;
    logic [15:0]   gens;
    logic [N-1:0]  states, arr_init;
    logic          arr_load, arr_step;
    logic          row_valid, row_ready, row_last;
    logic [W-1:0]  row_data;
    logic [4:0]    row_idx;
    logic [15:0]   gen_count;
    logic          done, stable;

    int nvec = 0;
    int nmis = 0;
    int step_cnt = 0;
    int load_cnt = 0;
    int overlap = 0;
    logic [N-1:0] model = '0;

    always #5 clock = ~clock;

    life_seq_ctrl dut (
        .clock(clock), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .run(run), .gens(gens), .states(states), .arr_load(arr_load), .arr_init(arr_init),
        .arr_step(arr_step), .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .row_idx(row_idx), .row_last(row_last), .gen_count(gen_count), .done(done), .stable(stable)
    );

    function automatic logic [N-1:0] life_next(input logic [N-1:0] s);
        logic [N-1:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            cnt += int'(s[((r + dr + H) % H) * W + ((c + dc + W) % W)]);
                n[r*W + c] = (cnt == 3) || (cnt == 2 && s[r*W + c]);
            end
        end
        return n;
    endfunction

    function automatic logic [N-1:0] pattern(input int p);
        logic [N-1:0] v;
        v = '0;
        case (p)
            1: begin v[8*W+7] = 1'b1; v[8*W+8] = 1'b1; v[8*W+9] = 1'b1; end
            2: begin v[4*W+4] = 1'b1; v[4*W+5] = 1'b1; v[5*W+4] = 1'b1; v[5*W+5] = 1'b1; end
            3: begin v[1*W+2] = 1'b1; v[2*W+3] = 1'b1; v[3*W+1] = 1'b1; v[3*W+2] = 1'b1; v[3*W+3] = 1'b1; end
            default: v = '0;
        endcase
        return v;
    endfunction

    // Cell array stand-in: takes arr_init on arr_load, advances one torus generation on arr_step.
    always @(posedge clock) begin
        if (arr_load && arr_step) overlap <= overlap + 1;
        if (arr_load) begin
            model    <= arr_init;
            load_cnt <= load_cnt + 1;
        end else if (arr_step) begin
            model    <= life_next(model);
            step_cnt <= step_cnt + 1;
        end
    end
    assign states = model;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; ld_valid = 1'b0; ld_data = 1'b0; run = 1'b0; gens = '0; row_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        int n;
        ld_valid = 1'b1; ld_data = b; n = 0;
        while (!ld_ready && n < 50) begin @(negedge clock); n++; end
        if (!ld_ready) begin
            nvec++; nmis++;
            $display("FAIL ld_ready_timeout: got ld_ready=0 expected 1 within 50 cycles");
        end else begin
            @(negedge clock);
        end
        ld_valid = 1'b0;
    endtask

    task automatic load(input logic [N-1:0] p);
        for (int i = 0; i < N; i++) send_bit(p[i]);
    endtask

    task automatic wait_valid(input int lim, output bit got);
        int n;
        n = 0;
        while (!row_valid && n < lim) begin @(negedge clock); n++; end
        got = row_valid;
    endtask

    task automatic collect_scan(input bit drop, output logic [N-1:0] snap, output bit ok);
        bit got;
        int n;
        ok = 1'b1; snap = '0;
        wait_valid(20, got);
        if (!got) begin ok = 1'b0; return; end
        if (drop) run = 1'b0;
        row_ready = 1'b1;
        for (int r = 0; r < H; r++) begin
            n = 0;
            while (!row_valid && n < 50) begin @(negedge clock); n++; end
            if (!row_valid || row_idx != 5'(r) || row_last != (r == H - 1)) ok = 1'b0;
            snap[r*W +: W] = row_data;
            @(negedge clock);
        end
        row_ready = 1'b0;
        if (row_valid) ok = 1'b0;
    endtask

    typedef struct {
        int          pat;
        logic [15:0] gens;
        int          max_scans;
        int          exp_gen;
        logic        exp_done;
        logic        exp_stable;
        int          exp_steps;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        logic [N-1:0] exp, snap, pat0;
        bit got, ok;
        int k, s0, l0;
        apply_reset();
        gens = v.gens; run = 1'b1;
        s0 = step_cnt; l0 = load_cnt;
        pat0 = pattern(v.pat);
        load(pat0);
        exp = pat0; k = 0;
        while (k < 100) begin
            wait_valid(12, got);
            if (!got) break;
            collect_scan(k == v.max_scans, snap, ok);
            chk($sformatf("v%0d_scan%0d_seq", idx, k), N'(ok), N'(1));
            chk($sformatf("v%0d_scan%0d_data", idx, k), snap, exp);
            if (v.pat == 1) begin
                if (k % 2 == 0) chk($sformatf("v%0d_blinker_row8", idx), N'(snap[8*W +: W]), N'(17'h00380));
                else            chk($sformatf("v%0d_blinker_row7", idx), N'(snap[7*W +: W]), N'(17'h00100));
            end
            if (v.pat == 3 && k == 68) chk($sformatf("v%0d_glider_wrap", idx), snap, pat0);
            exp = life_next(exp);
            k++;
        end
        chk($sformatf("v%0d_gen_count", idx), N'(gen_count), N'(v.exp_gen));
        chk($sformatf("v%0d_done", idx), N'(done), N'(v.exp_done));
        chk($sformatf("v%0d_stable", idx), N'(stable), N'(v.exp_stable));
        chk($sformatf("v%0d_steps", idx), N'(step_cnt - s0), N'(v.exp_steps));
        chk($sformatf("v%0d_loads", idx), N'(load_cnt - l0), N'(1));
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic [N-1:0] snap, g;
        logic [W-1:0] held;
        bit ok, got, seen;
        int n, s0, l0;

        vecs[0] = '{1, 16'd2, -1,  2, 1'b1, 1'b0,  2};
        vecs[1] = '{2, 16'd0, -1,  1, 1'b1, 1'b1,  1};
        vecs[2] = '{1, 16'd5, -1,  5, 1'b1, 1'b0,  5};
        vecs[3] = '{0, 16'd0, -1,  1, 1'b1, 1'b1,  1};
        vecs[4] = '{2, 16'd3, -1,  1, 1'b1, 1'b1,  1};
        vecs[5] = '{1, 16'd0,  3,  3, 1'b0, 1'b0,  3};
        vecs[6] = '{3, 16'd0, 68, 68, 1'b0, 1'b0, 68};

        // Reset state, sampled while reset is held.
        reset = 1'b1; ld_valid = 1'b0; ld_data = 1'b0; run = 1'b0; gens = '0; row_ready = 1'b0;
        #1;
        chk("reset_outputs", N'({ld_ready, arr_load, arr_step, row_valid, row_last, done, stable,
                                 |arr_init, |row_data, |row_idx, |gen_count}), '0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_ld_ready", N'(ld_ready), N'(1));

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Backpressure at row 3, then run=0 holds in PAUSE, then run=1 resumes.
        apply_reset();
        g = pattern(3);
        s0 = step_cnt; l0 = load_cnt;
        load(g);
        wait_valid(20, got);
        chk("bp_scan_start", N'(got), N'(1));
        row_ready = 1'b1;
        n = 0;
        while (row_idx != 5'd3 && n < 20) begin @(negedge clock); n++; end
        row_ready = 1'b0;
        held = row_data;
        chk("bp_row3_data", N'(held), N'(17'h0000E));
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk($sformatf("bp_hold%0d", c), N'({row_valid, row_idx, row_data}), N'({1'b1, 5'd3, 17'h0000E}));
        end
        chk("bp_no_step", N'(step_cnt - s0), N'(0));
        chk("bp_one_load", N'(load_cnt - l0), N'(1));
        row_ready = 1'b1;
        n = 0;
        while (row_valid && n < 30) begin @(negedge clock); n++; end
        row_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (row_valid || arr_step) seen = 1'b1;
        end
        chk("pause_idle_50", N'({seen, step_cnt - s0}), '0);
        chk("pause_gen0", N'(gen_count), N'(0));
        run = 1'b1;
        collect_scan(1'b1, snap, ok);
        chk("resume_scan_seq", N'(ok), N'(1));
        chk("resume_scan_data", snap, life_next(g));
        chk("resume_gen1", N'(gen_count), N'(1));

        // Reset mid-LOAD at ptr=100, then a fresh full load.
        apply_reset();
        for (int i = 0; i < 100; i++) send_bit(g[i]);
        reset = 1'b1;
        #1;
        chk("rst_midload_outputs", N'({ld_ready, arr_load, arr_step, row_valid, row_last, done, stable,
                                       |arr_init, |row_data, |row_idx, |gen_count}), '0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run = 1'b0;
        load(pattern(2));
        collect_scan(1'b0, snap, ok);
        chk("reload_scan_seq", N'(ok), N'(1));
        chk("reload_scan_data", snap, pattern(2));

        // Reset mid-SCAN at row 5, then a fresh full load.
        apply_reset();
        load(g);
        wait_valid(20, got);
        row_ready = 1'b1;
        n = 0;
        while (row_idx != 5'd5 && n < 20) begin @(negedge clock); n++; end
        reset = 1'b1; row_ready = 1'b0;
        #1;
        chk("rst_midscan_outputs", N'({ld_ready, arr_load, arr_step, row_valid, row_last, done, stable,
                                       |arr_init, |row_data, |row_idx, |gen_count}), '0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        load(pattern(1));
        collect_scan(1'b0, snap, ok);
        chk("rescan_seq", N'(ok), N'(1));
        chk("rescan_data", snap, pattern(1));

        chk("arr_load_step_overlap", N'(overlap), N'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
